testbasic1_feeder: RTL and testbench

- Buffered producer stage directly upstream of the TestBasic1 consumer. Drives that consumer's blocking integer input port (b_in / b_in_sync / b_in_notify).
- Accepts 32-bit integer samples on its own blocking input port and stores them in a DEPTH-entry FIFO.
- Optionally replaces each sample with a running sum before forwarding.
- Decouples the upstream source from consumer stalls.

---
 rtl/testbasic1_feeder.sv | 187 ++++++++++++++++++
 tb/tb_testbasic1_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/testbasic1_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : testbasic1_feeder
//  Purpose  : Buffered producer stage feeding the TestBasic1 consumer.
//             Samples arriving on the a_in blocking port are stored in a
//             DEPTH-entry FIFO, optionally replaced by a running sum, and
//             forwarded on the b_out blocking port. Upstream is decoupled
//             from consumer stalls; both handshakes decode registered
//             occupancy only, so no input reaches any output
//             combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module testbasic1_feeder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         a_in,
  input  logic                     a_in_sync,
  output logic                     a_in_notify,
  output logic [WIDTH-1:0]         b_out,
  output logic                     b_out_sync,
  input  logic                     b_out_notify,
  input  logic                     mode,
  input  logic                     acc_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     acc_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_EMPTY = '0;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Section encoding: a coarse view of occupancy used by the consumer side.
  localparam logic [1:0] SECTION_EMPTY  = 2'd0;
  localparam logic [1:0] SECTION_ACTIVE = 2'd1;
  localparam logic [1:0] SECTION_FULL   = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [LVL_W-1:0] level_q,   level_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic             ovf_q,     ovf_d;
  logic [WIDTH-1:0] last_q,    last_d;
  logic [1:0]       section_q, section_d;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_acc_base;
  logic [WIDTH-1:0] w_sum;
  logic             w_sum_ovf;
  logic [WIDTH-1:0] w_store;

  // Handshakes come straight from the registered level.
  assign a_in_notify = (level_q != LVL_FULL);
  assign b_out_sync  = (level_q != LVL_EMPTY);

  assign w_push = a_in_sync  && a_in_notify;
  assign w_pop  = b_out_sync && b_out_notify;

  assign w_head = mem_q[rd_ptr_q];

  // A clear coincident with an accumulating push makes that push start from
  // zero, so the clear takes effect before the add rather than after it.
  assign w_acc_base = acc_clr ? '0 : acc_q;
  assign w_sum      = w_acc_base + a_in;

  // Signed overflow: operands agree in sign and the result does not.
  assign w_sum_ovf = (w_acc_base[WIDTH-1] == a_in[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != w_acc_base[WIDTH-1]);

  assign w_store = mode ? w_sum : a_in;

  // While empty, the output keeps showing the last sample that left.
  assign b_out   = b_out_sync ? w_head : last_q;
  assign level   = level_q;
  assign acc_ovf = ovf_q;

  // Next-state for pointers, occupancy and the hold register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;

    // Pointers are power-of-two wide, so the increment wraps on its own.
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      last_d   = w_head;
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Next-state for the running sum and its sticky overflow flag.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;

    if (w_push && mode) begin
      acc_d = w_sum;
      if (w_sum_ovf) begin
        ovf_d = 1'b1;
      end
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  // Section tracking follows occupancy transitions driven by the transfers.
  always_comb begin
    section_d = section_q;
    case (section_q)
      SECTION_EMPTY: begin
        if (w_push && !w_pop) begin
          section_d = (level_d == LVL_FULL) ? SECTION_FULL : SECTION_ACTIVE;
        end
      end
      SECTION_ACTIVE: begin
        if (level_d == LVL_FULL) begin
          section_d = SECTION_FULL;
        end else if (level_d == LVL_EMPTY) begin
          section_d = SECTION_EMPTY;
        end
      end
      SECTION_FULL: begin
        if (w_pop) begin
          section_d = (level_d == LVL_EMPTY) ? SECTION_EMPTY : SECTION_ACTIVE;
        end
      end
      default: section_d = SECTION_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------

  // Control state; reset discards occupancy so stored data is abandoned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      last_q    <= '0;
      section_q <= SECTION_EMPTY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      last_q    <= last_d;
      section_q <= section_d;
    end
  end

  // Storage array; contents are meaningless while level says empty.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      mem_q[wr_ptr_q] <= w_store;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_testbasic1_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_testbasic1_feeder
//  Purpose  : Directed self-checking bench for testbasic1_feeder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_testbasic1_feeder;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  localparam logic [31:0] SEC_EMPTY  = 32'd0;
  localparam logic [31:0] SEC_ACTIVE = 32'd1;
  localparam logic [31:0] SEC_FULL   = 32'd2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a_in;
  logic             a_in_sync;
  logic             a_in_notify;
  logic [WIDTH-1:0] b_out;
  logic             b_out_sync;
  logic             b_out_notify;
  logic             mode;
  logic             acc_clr;
  logic [2:0]       level;
  logic             acc_ovf;

  int errors = 0;
  int checks = 0;

  testbasic1_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_in         (a_in),
    .a_in_sync    (a_in_sync),
    .a_in_notify  (a_in_notify),
    .b_out        (b_out),
    .b_out_sync   (b_out_sync),
    .b_out_notify (b_out_notify),
    .mode         (mode),
    .acc_clr      (acc_clr),
    .level        (level),
    .acc_ovf      (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Occupancy, both handshakes and section against one expected level.
  task automatic chk_state(input string tag, input int exp_level);
    logic [31:0] sec;
    sec = (exp_level == 0) ? SEC_EMPTY : (exp_level == DEPTH) ? SEC_FULL : SEC_ACTIVE;
    chk({tag, ".level"},   32'(level),       32'(exp_level));
    chk({tag, ".a_ready"}, 32'(a_in_notify), 32'(exp_level != DEPTH));
    chk({tag, ".b_valid"}, 32'(b_out_sync),  32'(exp_level != 0));
    chk({tag, ".section"}, 32'(dut.section_q), sec);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vals [3];
    vals = '{5, 7, 9};

    rst          = 1'b1;
    a_in         = '0;
    a_in_sync    = 1'b0;
    b_out_notify = 1'b0;
    mode         = 1'b0;
    acc_clr      = 1'b0;

    // Reset state
    #2;
    chk_state("reset", 0);
    chk("reset.b_out", b_out, 32'd0);
    chk("reset.ovf", 32'(acc_ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pass-through, one cycle latency, level never above 1
    b_out_notify = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in      = 32'(vals[i]);
      a_in_sync = 1'b1;
      step();
      chk("pass.b_out", b_out, 32'(vals[i]));
      chk_state("pass.after_push", 1);
      a_in_sync = 1'b0;
      step();
      chk("pass.hold", b_out, 32'(vals[i]));
      chk_state("pass.after_pop", 0);
    end

    // Fill to full with consumer stalled
    b_out_notify = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a_in      = 32'(i);
      a_in_sync = 1'b1;
      step();
      chk_state("fill", i);
    end
    a_in = 32'd5;
    step();
    chk_state("full.reject", 4);
    chk("full.head", b_out, 32'd1);
    b_out_notify = 1'b1;
    step();
    chk_state("full.pop_no_push", 3);
    chk("drain.1", b_out, 32'd2);
    step();
    chk_state("drain.push5", 3);
    chk("drain.2", b_out, 32'd3);
    a_in_sync = 1'b0;
    step();
    chk("drain.3", b_out, 32'd4);
    step();
    chk("drain.4", b_out, 32'd5);
    step();
    chk_state("drain.empty", 0);
    chk("drain.hold", b_out, 32'd5);

    // Accumulate mode and clear
    mode      = 1'b1;
    a_in_sync = 1'b1;
    a_in = 32'd10; step(); chk("acc.10", b_out, 32'd10);
    a_in = 32'd20; step(); chk("acc.30", b_out, 32'd30);
    a_in = 32'd30; step(); chk("acc.60", b_out, 32'd60);
    a_in = 32'd4; acc_clr = 1'b1; step(); chk("acc.clr4", b_out, 32'd4);
    a_in = 32'd1; acc_clr = 1'b0; step(); chk("acc.5", b_out, 32'd5);
    chk("acc.reg", dut.acc_q, 32'd5);
    chk("acc.no_ovf", 32'(acc_ovf), 32'd0);
    a_in_sync = 1'b0;
    step();
    chk_state("acc.empty", 0);

    // Signed overflow is sticky
    a_in_sync = 1'b1;
    a_in = 32'h7FFF_FFFF; acc_clr = 1'b1; step();
    chk("ovf.max", b_out, 32'h7FFF_FFFF);
    chk("ovf.not_yet", 32'(acc_ovf), 32'd0);
    a_in = 32'd1; acc_clr = 1'b0; step();
    chk("ovf.wrap", b_out, 32'h8000_0000);
    chk("ovf.set", 32'(acc_ovf), 32'd1);
    a_in = 32'd5; step();
    chk("ovf.next", b_out, 32'h8000_0005);
    chk("ovf.sticky1", 32'(acc_ovf), 32'd1);
    mode = 1'b0; a_in = 32'd9; step();
    chk("ovf.mode0", b_out, 32'd9);
    chk("ovf.acc_kept", dut.acc_q, 32'h8000_0005);
    chk("ovf.sticky2", 32'(acc_ovf), 32'd1);
    a_in_sync = 1'b0;
    step();
    chk_state("ovf.empty", 0);

    // Steady push+pop at level 2 across pointer wrap
    b_out_notify = 1'b0;
    a_in_sync    = 1'b1;
    a_in = 32'd100; step();
    a_in = 32'd101; step();
    chk_state("stream.prefill", 2);
    b_out_notify = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      a_in = 32'(101 + k);
      step();
      chk("stream.data", b_out, 32'(100 + k));
      chk_state("stream", 2);
    end
    a_in_sync    = 1'b0;
    b_out_notify = 1'b0;
    step();
    chk_state("stream.idle", 2);
    chk("stream.head", b_out, 32'd110);

    // Asynchronous reset mid-operation
    a_in_sync = 1'b1;
    a_in = 32'd200;
    step();
    chk_state("prereset", 3);
    a_in_sync = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0);
    chk("async_rst.b_out", b_out, 32'd0);
    chk("async_rst.acc", dut.acc_q, 32'd0);
    chk("async_rst.ovf", 32'(acc_ovf), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk_state("post_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
